display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Sequences the 4-digit 7-segment display path. A prescaler sets the refresh rate.
//  A one-hot scan state machine drives the digit-select mux and the common anodes.
//  New BCD values arrive on a valid/ready handshake and apply only at frame boundaries (no tearing).
//  Optional leading-zero blanking. Sits between the BCD converter and the digit mux / segment decoder.
// PARAMETERS
//  REFRESH_DIV  27000  clk cycles per digit slot (>=1); 27 MHz -> ~1 kHz/digit
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst          in   1   synchronous reset, active-high
//  bcd_in       in   16  [3:0]=unidades [7:4]=decenas [11:8]=centenas [15:12]=millares
//  bcd_valid    in   1   bcd_in valid; held until accepted
//  bcd_ready    out  1   controller can accept bcd_in
//  blank_en     in   1   1 = blank leading zero digits
//  sel          out  4   one-hot digit select to mux (0001 uni, 0010 dec, 0100 cen, 1000 mil)
//  cdu_out      out  16  displayed BCD word, feeds mux data input
//  an_n         out  4   active-low anode enables, bit i = digit i
//  frame_start  out  1   1-cycle pulse when scan wraps to unidades
// BEHAVIOUR
//  Reset (rst=1 at clk edge), all regs:
//   - prescaler=0, sel=0001, cdu_out=0, shadow=0, pending=0, frame_start=0.
//   - Outputs: bcd_ready=1, an_n=1110.
//  Prescaler:
//   - Counts 0..REFRESH_DIV-1, wraps to 0.
//   - tick=1 in the cycle count==REFRESH_DIV-1. REFRESH_DIV=1 -> tick every cycle.
//  Scan FSM (state register IS sel, one-hot):
//   - On tick: UNI->DEC->CEN->MIL->UNI. No tick: hold.
//   - Illegal (non-one-hot) sel -> UNI on next clock.
//  Frame boundary:
//   - The clock edge where tick=1 and sel==MIL.
//   - At that edge: sel<=0001, frame_start<=1 (registered; low otherwise).
//   - Also at that edge, if pending=1: cdu_out<=shadow, pending<=0.
//  Handshake:
//   - bcd_ready = ~pending (combinational).
//   - Transfer when bcd_valid&&bcd_ready at clock edge: shadow<=bcd_in, pending<=1.
//   - While pending, valid is ignored; upstream holds data.
//   - The boundary that clears pending cannot accept in the same cycle (ready=0). The next word is accepted the following cycle at earliest.
//   - A word accepted in the cycle of a boundary edge (pending was 0) waits for the next boundary.
//  Blanking (combinational from registered sel/cdu_out, zero latency):
//   - an_n = ~sel, except the active digit is forced off (an_n=1111) when blank_en=1 and:
//     - MIL: cdu_out[15:12]==0
//     - CEN: cdu_out[15:8]==0
//     - DEC: cdu_out[15:4]==0
//   - UNI is never blanked (value 0 shows "0").
//  Width/values:
//   - Nibbles >9 pass through unmodified; no BCD checking.
//   - Prescaler width = $clog2(REFRESH_DIV+1).
//  Reset mid-operation:
//   - Pending word discarded; cdu_out cleared; scan restarts at UNI with prescaler=0.
// TESTING (REFRESH_DIV=4)
//  1 reset: rst 1 cycle -> sel=0001, an_n=1110, bcd_ready=1, cdu_out=0000, frame_start=0.
//  2 scan: free run -> sel 0010 at cycle 4, 0100 at 8, 1000 at 12, 0001 at 16 with frame_start=1 for exactly 1 cycle.
//  3 handshake: 0x1234 valid 1 cycle mid-frame -> ready=0 next cycle, cdu_out=0 until boundary, then cdu_out=0x1234, ready=1.
//  4 backpressure: 0x1234 pending, hold 0x5678 valid -> not taken until ready=1; cdu_out=0x5678 one frame later.
//  5 blanking: cdu_out=0x0045, blank_en=1 -> an_n=1111 in MIL/CEN, 1101 in DEC, 1110 in UNI; blank_en=0 -> all digits lit.
//  6 rst mid-op: accept 0x9999, assert rst before boundary -> cdu_out=0, ready=1, sel=0001, no frame_start.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Refresh scan sequencer for a 4-digit multiplexed 7-segment display.
// BCD words are double-buffered and only swapped in at frame boundaries, so a frame never shows two different values.
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 27000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        bcd_valid,
  output logic        bcd_ready,
  input  logic        blank_en,
  output logic [3:0]  sel,
  output logic [15:0] cdu_out,
  output logic [3:0]  an_n,
  output logic        frame_start
);

  localparam int PW = $clog2(REFRESH_DIV + 1);
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

  typedef enum logic [3:0] {
    UNI = 4'b0001,
    DEC = 4'b0010,
    CEN = 4'b0100,
    MIL = 4'b1000
  } scan_e;

  scan_e         sel_q, sel_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   shadow_q;
  logic [15:0]   cdu_q;
  logic          pending_q;
  logic          fs_q;
  logic          tick;
  logic          boundary;
  logic          accept;
  logic          blank;

  always_comb begin
    tick     = (presc_q == LAST);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    boundary = tick && (sel_q == MIL);
    accept   = bcd_valid && !pending_q;
  end

  // Any non-one-hot state falls back to the units digit on the next clock.
  always_comb begin
    sel_d = UNI;
    case (sel_q)
      UNI:     sel_d = tick ? DEC : UNI;
      DEC:     sel_d = tick ? CEN : DEC;
      CEN:     sel_d = tick ? MIL : CEN;
      MIL:     sel_d = tick ? UNI : MIL;
      default: sel_d = UNI;
    endcase
  end

  // Accept and frame swap are mutually exclusive: accept needs pending low, swap needs it high.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      sel_q     <= UNI;
      shadow_q  <= '0;
      cdu_q     <= '0;
      pending_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sel_q   <= sel_d;
      fs_q    <= boundary;
      if (accept) begin
        shadow_q  <= bcd_in;
        pending_q <= 1'b1;
      end else if (boundary && pending_q) begin
        cdu_q     <= shadow_q;
        pending_q <= 1'b0;
      end
    end
  end

  // Leading-zero blanking: a digit is dark when it and every higher digit are zero.
  always_comb begin
    blank = 1'b0;
    case (sel_q)
      MIL:     blank = (cdu_q[15:12] == 4'h0);
      CEN:     blank = (cdu_q[15:8] == 8'h00);
      DEC:     blank = (cdu_q[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
    an_n = (blank_en && blank) ? 4'hF : ~sel_q;
  end

  assign sel         = sel_q;
  assign cdu_out     = cdu_q;
  assign bcd_ready   = ~pending_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed and randomized check of display_scan_ctrl against a cycle-count reference model.
module tb_display_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic        bcd_valid;
  logic        bcd_ready;
  logic        blank_en;
  logic [3:0]  sel;
  logic [15:0] cdu_out;
  logic [3:0]  an_n;
  logic        frame_start;

  int total = 0;
  int bad   = 0;

  // Reference model: position in the frame is just a cycle count since reset.
  int          m_cyc;
  logic [15:0] m_cdu;
  logic [15:0] m_shadow;
  bit          m_pend;
  bit          m_fs;
  bit          m_acc;

  display_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .bcd_in      (bcd_in),
    .bcd_valid   (bcd_valid),
    .bcd_ready   (bcd_ready),
    .blank_en    (blank_en),
    .sel         (sel),
    .cdu_out     (cdu_out),
    .an_n        (an_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_digit();
    return (m_cyc / DIV) % 4;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_cdu = '0; m_shadow = '0; m_pend = 0; m_fs = 0; m_acc = 0;
  endtask

  task automatic model_step();
    bit tick, bnd;
    if (rst) begin
      model_reset();
    end else begin
      tick  = (m_cyc % DIV) == DIV - 1;
      bnd   = tick && (m_digit() == 3);
      m_acc = bcd_valid && !m_pend;
      m_fs  = bnd;
      if (m_acc) begin
        m_shadow = bcd_in;
        m_pend   = 1;
      end else if (bnd && m_pend) begin
        m_cdu  = m_shadow;
        m_pend = 0;
      end
      m_cyc = (m_cyc + 1) % (4 * DIV);
    end
  endtask

  task automatic check_all();
    int d;
    logic [3:0] e_sel, e_an;
    bit blank;
    d     = m_digit();
    e_sel = 4'(1 << d);
    blank = blank_en && (d != 0) && ((m_cdu >> (4 * d)) == 0);
    e_an  = blank ? 4'hF : ~e_sel;
    chk("sel", {12'b0, sel}, {12'b0, e_sel});
    chk("an_n", {12'b0, an_n}, {12'b0, e_an});
    chk("ready", {15'b0, bcd_ready}, {15'b0, !m_pend});
    chk("cdu_out", cdu_out, m_cdu);
    chk("frame_start", {15'b0, frame_start}, {15'b0, m_fs});
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (frame_start !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    chk(tag, {15'b0, frame_start}, 16'd1);
  endtask

  initial begin
    int n;
    logic [3:0] tbl_an [4];
    rst = 1'b1; bcd_in = '0; bcd_valid = 1'b0; blank_en = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    rst = 1'b0;

    chk("rst_sel", {12'b0, sel}, 16'h0001);
    chk("rst_an", {12'b0, an_n}, 16'h000E);
    chk("rst_ready", {15'b0, bcd_ready}, 16'd1);
    chk("rst_cdu", cdu_out, 16'h0000);
    chk("rst_fs", {15'b0, frame_start}, 16'd0);

    repeat (4) cycle();
    chk("scan_c4", {12'b0, sel}, 16'h0002);
    repeat (4) cycle();
    chk("scan_c8", {12'b0, sel}, 16'h0004);
    repeat (4) cycle();
    chk("scan_c12", {12'b0, sel}, 16'h0008);
    chk("scan_c12_fs", {15'b0, frame_start}, 16'd0);
    repeat (4) cycle();
    chk("scan_c16", {12'b0, sel}, 16'h0001);
    chk("scan_c16_fs", {15'b0, frame_start}, 16'd1);
    cycle();
    chk("scan_c17_fs", {15'b0, frame_start}, 16'd0);

    bcd_in = 16'h1234; bcd_valid = 1'b1;
    cycle();
    bcd_valid = 1'b0;
    chk("hs_ready_low", {15'b0, bcd_ready}, 16'd0);
    chk("hs_cdu_hold", cdu_out, 16'h0000);
    wait_frame("hs_boundary");
    chk("hs_cdu", cdu_out, 16'h1234);
    chk("hs_ready_high", {15'b0, bcd_ready}, 16'd1);

    bcd_in = 16'h1234; bcd_valid = 1'b1;
    cycle();
    bcd_in = 16'h5678;
    chk("bp_ready_low", {15'b0, bcd_ready}, 16'd0);
    m_acc = 0;
    n = 0;
    while (!m_acc && n < 40) begin
      cycle();
      n++;
    end
    bcd_valid = 1'b0;
    chk("bp_accepted", {15'b0, m_acc}, 16'd1);
    chk("bp_cdu_first", cdu_out, 16'h1234);
    chk("bp_ready_low2", {15'b0, bcd_ready}, 16'd0);
    wait_frame("bp_boundary");
    chk("bp_cdu_second", cdu_out, 16'h5678);

    bcd_in = 16'h0045; bcd_valid = 1'b1;
    cycle();
    bcd_valid = 1'b0;
    wait_frame("bl_boundary");
    chk("bl_cdu", cdu_out, 16'h0045);
    tbl_an[0] = 4'b1110; tbl_an[1] = 4'b1101; tbl_an[2] = 4'b1111; tbl_an[3] = 4'b1111;
    blank_en = 1'b1;
    repeat (16) begin
      cycle();
      chk("bl_on_an", {12'b0, an_n}, {12'b0, tbl_an[m_digit()]});
    end
    blank_en = 1'b0;
    repeat (16) begin
      cycle();
      chk("bl_off_an", {12'b0, an_n}, {12'b0, ~(4'(1 << m_digit()))});
    end

    bcd_in = 16'h9999; bcd_valid = 1'b1;
    cycle();
    bcd_valid = 1'b0;
    chk("ro_ready_low", {15'b0, bcd_ready}, 16'd0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("ro_cdu", cdu_out, 16'h0000);
    chk("ro_ready", {15'b0, bcd_ready}, 16'd1);
    chk("ro_sel", {12'b0, sel}, 16'h0001);
    chk("ro_fs", {15'b0, frame_start}, 16'd0);
    repeat (12) begin
      cycle();
      chk("ro_no_fs", {15'b0, frame_start}, 16'd0);
    end
    chk("ro_cdu_after", cdu_out, 16'h0000);

    repeat (3000) begin
      bcd_in    = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3)));
      bcd_valid = ($urandom_range(0, 3) == 0);
      blank_en  = $urandom_range(0, 1) != 0;
      rst       = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0; bcd_valid = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
